// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: arbitrate, issue one op, return its result.
// Optional build macro ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie (round-robin when undefined).
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req0Valid,
  input  logic              req1Valid,
  output logic              req0Ready,
  output logic              req1Ready,
  input  logic [DATA_W-1:0] req0Op1,
  input  logic [DATA_W-1:0] req0Op2,
  input  logic [2:0]        req0Aluop,
  input  logic              req0ShiftEnable,
  input  logic              req0ShiftDirection,
  input  logic [DATA_W-1:0] req1Op1,
  input  logic [DATA_W-1:0] req1Op2,
  input  logic [2:0]        req1Aluop,
  input  logic              req1ShiftEnable,
  input  logic              req1ShiftDirection,
  output logic [DATA_W-1:0] aluOp1,
  output logic [DATA_W-1:0] aluOp2,
  output logic [2:0]        aluAluop,
  output logic              aluShiftEnable,
  output logic              aluShiftDirection,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluEqual,
  input  logic              aluLessThan,
  output logic              respValid,
  input  logic              respReady,
  output logic              respId,
  output logic [DATA_W-1:0] respResult,
  output logic              respEqual,
  output logic              respLessThan,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;

  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [2:0]          r_aluop;
  logic                r_shift_en;
  logic                r_shift_dir;
  logic                r_id;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_result;
  logic                r_resp_equal;
  logic                r_resp_less;
  logic                r_busy;

  logic [DATA_W-1:0]   w_sel_op1;
  logic [DATA_W-1:0]   w_sel_op2;
  logic [2:0]          w_sel_aluop;
  logic                w_sel_shift_en;
  logic                w_sel_shift_dir;

  // Grant decision: only in IDLE, purely from current valids and the last winner.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == IDLE) begin
      if (req0Valid && req1Valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_grant0 = 1'b1;
        w_grant1 = 1'b0;
`else
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
`endif
      end else begin
        w_grant0 = req0Valid;
        w_grant1 = req1Valid;
      end
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  assign w_accept  = w_grant0 | w_grant1;
  assign req0Ready = w_grant0;
  assign req1Ready = w_grant1;

  assign w_sel_op1       = w_grant1 ? req1Op1            : req0Op1;
  assign w_sel_op2       = w_grant1 ? req1Op2            : req0Op2;
  assign w_sel_aluop     = w_grant1 ? req1Aluop          : req0Aluop;
  assign w_sel_shift_en  = w_grant1 ? req1ShiftEnable    : req0ShiftEnable;
  assign w_sel_shift_dir = w_grant1 ? req1ShiftDirection : req0ShiftDirection;

  // Next-state logic: one EXEC cycle, then hold RESP until the consumer takes it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = EXEC;
        else          w_next_state = IDLE;
      end
      EXEC: w_next_state = RESP;
      RESP: begin
        if (respReady) w_next_state = IDLE;
        else           w_next_state = RESP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Operation latch, response capture and status flags; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_last_grant  <= 1'b1;
      r_op1         <= '0;
      r_op2         <= '0;
      r_aluop       <= 3'd0;
      r_shift_en    <= 1'b0;
      r_shift_dir   <= 1'b0;
      r_id          <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_equal  <= 1'b0;
      r_resp_less   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op1        <= w_sel_op1;
        r_op2        <= w_sel_op2;
        r_aluop      <= w_sel_aluop;
        r_shift_en   <= w_sel_shift_en;
        r_shift_dir  <= w_sel_shift_dir;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
      if (r_state == EXEC) begin
        r_resp_result <= aluResult;
        r_resp_equal  <= aluEqual;
        r_resp_less   <= aluLessThan;
      end
      r_resp_valid <= (w_next_state == RESP);
      r_busy       <= (w_next_state != IDLE);
    end
  end

  assign aluOp1            = r_op1;
  assign aluOp2            = r_op2;
  assign aluAluop          = r_aluop;
  assign aluShiftEnable    = r_shift_en;
  assign aluShiftDirection = r_shift_dir;
  assign respValid         = r_resp_valid;
  assign respId            = r_id;
  assign respResult        = r_resp_result;
  assign respEqual         = r_resp_equal;
  assign respLessThan      = r_resp_less;
  assign busy              = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner-case sequences, random vs reference model.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       req0Valid, req1Valid, req0Ready, req1Ready;
  logic [7:0] req0Op1, req0Op2, req1Op1, req1Op2;
  logic [2:0] req0Aluop, req1Aluop;
  logic       req0ShiftEnable, req0ShiftDirection, req1ShiftEnable, req1ShiftDirection;
  logic [7:0] aluOp1, aluOp2, aluResult;
  logic [2:0] aluAluop;
  logic       aluShiftEnable, aluShiftDirection, aluEqual, aluLessThan;
  logic       respValid, respReady, respId, respEqual, respLessThan, busy;
  logic [7:0] respResult;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared ALU environment model: shift overrides opcode; flags always compare op1 with op2.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input logic se, input logic sd);
    if (se) return sd ? (a >> 1) : (a << 1);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return 8'(a + b);
      3'd4:    return 8'(a - b);
      3'd6:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign aluResult   = alu_f(aluOp1, aluOp2, aluAluop, aluShiftEnable, aluShiftDirection);
  assign aluEqual    = (aluOp1 == aluOp2);
  assign aluLessThan = (aluOp1 < aluOp2);

  alu_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rstN(rstN),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .req0Op1(req0Op1), .req0Op2(req0Op2), .req0Aluop(req0Aluop),
    .req0ShiftEnable(req0ShiftEnable), .req0ShiftDirection(req0ShiftDirection),
    .req1Op1(req1Op1), .req1Op2(req1Op2), .req1Aluop(req1Aluop),
    .req1ShiftEnable(req1ShiftEnable), .req1ShiftDirection(req1ShiftDirection),
    .aluOp1(aluOp1), .aluOp2(aluOp2), .aluAluop(aluAluop),
    .aluShiftEnable(aluShiftEnable), .aluShiftDirection(aluShiftDirection),
    .aluResult(aluResult), .aluEqual(aluEqual), .aluLessThan(aluLessThan),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respResult(respResult), .respEqual(respEqual), .respLessThan(respLessThan),
    .busy(busy)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit r, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic se, input logic sd);
    if (r) begin
      req1Op1 = a; req1Op2 = b; req1Aluop = op; req1ShiftEnable = se; req1ShiftDirection = sd;
    end else begin
      req0Op1 = a; req0Op2 = b; req0Aluop = op; req0ShiftEnable = se; req0ShiftDirection = sd;
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    req0Valid = 1'b0; req1Valid = 1'b0; respReady = 1'b0;
    set_req(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    set_req(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
  endtask

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [2:0] aluop;
    logic       se;
    logic       sd;
    logic       exp_id;
    logic [7:0] exp_res;
    logic       exp_eq;
    logic       exp_lt;
  } vec_t;

  vec_t vecs[6];

  // One single-requester transaction with fixed latency: accept, EXEC, RESP, IDLE.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    set_req(1'b0, v.op1, v.op2, v.aluop, v.se, v.sd);
    set_req(1'b1, v.op1, v.op2, v.aluop, v.se, v.sd);
    req0Valid = v.v0; req1Valid = v.v1; respReady = 1'b1;
    #1;
    chk1("vec_ready0", req0Ready, v.v0);
    chk1("vec_ready1", req1Ready, v.v1);
    @(posedge clk);
    #1;
    req0Valid = 1'b0; req1Valid = 1'b0;
    @(negedge clk);
    chk1("vec_exec_respvalid", respValid, 1'b0);
    chk1("vec_exec_busy", busy, 1'b1);
    chk8("vec_exec_aluop1", aluOp1, v.op1);
    chk8("vec_exec_aluop2", aluOp2, v.op2);
    chk8("vec_exec_aluaop", {5'd0, aluAluop}, {5'd0, v.aluop});
    chk1("vec_exec_alu_se", aluShiftEnable, v.se);
    chk1("vec_exec_alu_sd", aluShiftDirection, v.sd);
    @(negedge clk);
    chk1("vec_resp_valid", respValid, 1'b1);
    chk1("vec_resp_id", respId, v.exp_id);
    chk8("vec_resp_result", respResult, v.exp_res);
    chk1("vec_resp_equal", respEqual, v.exp_eq);
    chk1("vec_resp_less", respLessThan, v.exp_lt);
    chk8("vec_resp_aluop1_hold", aluOp1, v.op1);
    @(negedge clk);
    chk1("vec_idle_busy", busy, 1'b0);
    chk1("vec_idle_respvalid", respValid, 1'b0);
  endtask

  // Reference model state for the random phase.
  bit         m_pend;
  int         m_age;
  bit         m_last;
  bit         m_id;
  logic [7:0] m_op1, m_op2;
  logic [2:0] m_aop;
  logic       m_se, m_sd;

  initial begin
    int got;
    bit e0, e1;
    //                v0    v1    op1    op2    aop   se    sd    id    res    eq    lt
    vecs[0] = '{1'b1, 1'b0, 8'h7F, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h03, 8'h09, 3'd5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h03, 3'd4, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h22, 8'h22, 3'd7, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h81, 8'h10, 3'd3, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h81, 8'hFF, 3'd0, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1};

    do_reset();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_respvalid", respValid, 1'b0);
    chk1("rst_respid", respId, 1'b0);
    chk8("rst_respresult", respResult, 8'h00);
    chk1("rst_respequal", respEqual, 1'b0);
    chk1("rst_respless", respLessThan, 1'b0);
    chk8("rst_aluop1", aluOp1, 8'h00);
    chk8("rst_aluop2", aluOp2, 8'h00);
    chk8("rst_aluaop", {5'd0, aluAluop}, 8'h00);
    chk1("rst_ready0", req0Ready, 1'b0);
    chk1("rst_ready1", req1Ready, 1'b0);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Both requesters valid every cycle: winners alternate (or always 0 with fixed priority).
    do_reset();
    set_req(1'b0, 8'h05, 8'h03, 3'd4, 1'b0, 1'b0);
    set_req(1'b1, 8'h22, 8'h22, 3'd7, 1'b0, 1'b0);
    req0Valid = 1'b1; req1Valid = 1'b1; respReady = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (respValid) begin
        bit eid;
        eid = FIXED ? 1'b0 : got[0];
        chk1("seqA_id", respId, eid);
        chk8("seqA_result", respResult, eid ? 8'h00 : 8'h02);
        chk1("seqA_equal", respEqual, eid);
        got++;
      end
    end
    chk8("seqA_count", 8'(got), 8'd4);
    req0Valid = 1'b0; req1Valid = 1'b0;

    // Backpressure: five RESP cycles with respReady low.
    do_reset();
    @(negedge clk);
    set_req(1'b0, 8'h7F, 8'h01, 3'd3, 1'b0, 1'b0);
    set_req(1'b1, 8'h11, 8'h44, 3'd1, 1'b0, 1'b0);
    req0Valid = 1'b1; respReady = 1'b0;
    @(posedge clk);
    #1;
    req1Valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk1("seqB_respvalid", respValid, 1'b1);
      chk8("seqB_result", respResult, 8'h80);
      chk1("seqB_id", respId, 1'b0);
      chk1("seqB_ready0", req0Ready, 1'b0);
      chk1("seqB_ready1", req1Ready, 1'b0);
      chk1("seqB_busy", busy, 1'b1);
    end
    @(negedge clk);
    respReady = 1'b1; req0Valid = 1'b0; req1Valid = 1'b0;
    #1;
    chk1("seqB_last_valid", respValid, 1'b1);
    @(negedge clk);
    chk1("seqB_idle_busy", busy, 1'b0);
    chk1("seqB_idle_valid", respValid, 1'b0);

    // Reset pulse in EXEC discards the op; next tie goes to requester 0.
    do_reset();
    @(negedge clk);
    set_req(1'b1, 8'h0F, 8'h01, 3'd3, 1'b0, 1'b0);
    req1Valid = 1'b1; respReady = 1'b1;
    @(posedge clk);
    #1;
    req1Valid = 1'b0;
    @(negedge clk);
    chk1("seqC_exec_busy", busy, 1'b1);
    rstN = 1'b0;
    #1;
    chk1("seqC_rst_busy", busy, 1'b0);
    chk1("seqC_rst_valid", respValid, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("seqC_no_resp", respValid, 1'b0);
    end
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    chk1("seqC_tie_ready0", req0Ready, 1'b1);
    chk1("seqC_tie_ready1", req1Ready, 1'b0);
    req0Valid = 1'b0; req1Valid = 1'b0;

    // Random traffic against the reference model.
    do_reset();
    m_pend = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
    m_op1 = 8'h00; m_op2 = 8'h00; m_aop = 3'd0; m_se = 1'b0; m_sd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req0Valid = 1'($urandom_range(0, 1));
      req1Valid = 1'($urandom_range(0, 1));
      respReady = ($urandom_range(0, 3) != 0);
      set_req(1'b0, 8'($urandom), 8'($urandom_range(0, 15)), 3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      set_req(1'b1, 8'($urandom_range(0, 15)), 8'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (!m_pend) begin
        if (req0Valid && req1Valid) begin
          e0 = FIXED ? 1'b1 : m_last;
          e1 = ~e0;
        end else begin
          e0 = req0Valid;
          e1 = req1Valid;
        end
      end
      chk1("rnd_ready0", req0Ready, e0);
      chk1("rnd_ready1", req1Ready, e1);
      chk1("rnd_busy", busy, m_pend);
      chk1("rnd_respvalid", respValid, m_pend && m_age >= 2);
      chk8("rnd_aluop1", aluOp1, m_op1);
      chk8("rnd_aluop2", aluOp2, m_op2);
      chk8("rnd_aluaop", {5'd0, aluAluop}, {5'd0, m_aop});
      chk1("rnd_alu_se", aluShiftEnable, m_se);
      chk1("rnd_alu_sd", aluShiftDirection, m_sd);
      if (m_pend && m_age >= 2) begin
        chk1("rnd_resp_id", respId, m_id);
        chk8("rnd_resp_result", respResult, alu_f(m_op1, m_op2, m_aop, m_se, m_sd));
        chk1("rnd_resp_equal", respEqual, m_op1 == m_op2);
        chk1("rnd_resp_less", respLessThan, m_op1 < m_op2);
      end
      @(posedge clk);
      if (m_pend) begin
        if (m_age >= 2 && respReady) m_pend = 1'b0;
        else m_age++;
      end else if (e0 || e1) begin
        m_pend = 1'b1; m_age = 1; m_last = e1; m_id = e1;
        m_op1 = e1 ? req1Op1 : req0Op1;
        m_op2 = e1 ? req1Op2 : req0Op2;
        m_aop = e1 ? req1Aluop : req0Aluop;
        m_se  = e1 ? req1ShiftEnable : req0ShiftEnable;
        m_sd  = e1 ? req1ShiftDirection : req0ShiftDirection;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
